// File: rtl/icache_lite_pkg.sv
// icache_lite shared definitions: geometry, address split, FSM state type
// and the refill address helper.
package icache_lite_pkg;

  localparam int XLEN       = 32;
  localparam int SETS       = 16;
  localparam int LINE_WORDS = 4;

  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = XLEN - INDEX_W - OFFSET_W - 2;

  typedef logic [XLEN-1:0]     word_t;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [OFFSET_W-1:0] offset_t;

  // Word address (byte bits stripped) split into its cache fields.
  typedef struct packed {
    tag_t    tag;
    index_t  index;
    offset_t offset;
  } waddr_t;

  localparam offset_t OFFSET_ZERO = offset_t'(0);
  localparam offset_t OFFSET_ONE  = offset_t'(1);
  localparam offset_t LAST_WORD   = offset_t'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Byte address of one word inside a line.
  function automatic word_t line_word_addr(input tag_t tag, input index_t index,
                                           input offset_t offset);
    return {tag, index, offset, 2'b00};
  endfunction

endpackage

// File: rtl/icache_lite_if.sv
// Fetch-side request/ack and memory-side refill bus of icache_lite.
// The slave modport is the cache's view, master is the surrounding core.
interface icache_lite_if;
  import icache_lite_pkg::*;

  logic  req_i;
  word_t addr_i;
  logic  kill_i;
  logic  flush_i;
  word_t r_data_o;
  logic  ack_o;
  logic  mem_req_o;
  word_t mem_addr_o;
  word_t mem_rdata_i;
  logic  mem_ack_i;

  modport slave (
    input  req_i, addr_i, kill_i, flush_i, mem_rdata_i, mem_ack_i,
    output r_data_o, ack_o, mem_req_o, mem_addr_o
  );

  modport master (
    output req_i, addr_i, kill_i, flush_i, mem_rdata_i, mem_ack_i,
    input  r_data_o, ack_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/icache_lite_array.sv
// Tag/valid/data storage for icache_lite: one combinational read port,
// one word write port, a tag+valid install port and a global valid clear.
module icache_lite_array
  import icache_lite_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  index_t  i_rd_index,
  input  offset_t i_rd_offset,
  output word_t   o_rd_data,
  output tag_t    o_rd_tag,
  output logic    o_rd_valid,
  input  logic    i_wr_en,
  input  index_t  i_wr_index,
  input  offset_t i_wr_offset,
  input  word_t   i_wr_data,
  input  logic    i_set_en,
  input  index_t  i_set_index,
  input  tag_t    i_set_tag,
  input  logic    i_set_valid,
  input  logic    i_clr_all
);

  logic [SETS-1:0] r_valid;
  tag_t            r_tag  [SETS];
  word_t           r_data [SETS][LINE_WORDS];

  // Valid bits: reset and flush clear every line; clear beats a same-cycle install.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= {SETS{1'b0}};
    end else if (i_clr_all) begin
      r_valid <= {SETS{1'b0}};
    end else if (i_set_en) begin
      r_valid[i_set_index] <= i_set_valid;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Tag store, written once per line install; contents only matter when valid.
  always_ff @(posedge clk) begin
    if (i_set_en) begin
      r_tag[i_set_index] <= i_set_tag;
    end
  end

  // Data store, one refill word per write.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_index][i_wr_offset] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_data[i_rd_index][i_rd_offset];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_valid = r_valid[i_rd_index];

endmodule

// File: rtl/icache_lite.sv
// icache_lite: direct-mapped read-only instruction cache. Hits answer one
// cycle after the request; misses refill the whole line word by word in
// order and then answer from the RESP state.
module icache_lite
  import icache_lite_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  icache_lite_if.slave  bus
);

  state_e  r_state;
  tag_t    r_tag;
  index_t  r_index;
  offset_t r_offset;
  offset_t r_cnt;
  logic    r_kill;
  logic    r_flush_pend;
  logic    r_ack;
  word_t   r_rdata;
  word_t   r_resp_word;
  logic    r_mem_req;
  word_t   r_mem_addr;

  waddr_t     w_req;
  logic [1:0] w_unused_byte;
  word_t      w_rd_data;
  tag_t       w_rd_tag;
  logic       w_rd_valid;
  logic       w_lookup;
  logic       w_hit;
  logic       w_word_ack;
  logic       w_last;

  // Byte-offset bits of the fetch address play no part in the lookup.
  assign w_unused_byte = bus.addr_i[1:0];
  assign w_req         = waddr_t'(bus.addr_i[XLEN-1:2]);

  assign w_lookup   = (r_state == IDLE) && bus.req_i && !bus.kill_i && !bus.flush_i;
  assign w_hit      = w_rd_valid && (w_rd_tag == w_req.tag);
  assign w_word_ack = (r_state == REFILL) && bus.mem_ack_i;
  // Terminal count decides the end of the refill, not a wrapped counter value.
  assign w_last     = (r_cnt == LAST_WORD);

  icache_lite_array u_array (
    .clk         (clk),
    .rst         (rst),
    .i_rd_index  (w_req.index),
    .i_rd_offset (w_req.offset),
    .o_rd_data   (w_rd_data),
    .o_rd_tag    (w_rd_tag),
    .o_rd_valid  (w_rd_valid),
    .i_wr_en     (w_word_ack),
    .i_wr_index  (r_index),
    .i_wr_offset (r_cnt),
    .i_wr_data   (bus.mem_rdata_i),
    .i_set_en    (w_word_ack && w_last),
    .i_set_index (r_index),
    .i_set_tag   (r_tag),
    .i_set_valid (!r_flush_pend),
    .i_clr_all   (bus.flush_i)
  );

  // Control FSM: lookup in IDLE, in-order line refill, then one response cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tag        <= {TAG_W{1'b0}};
      r_index      <= {INDEX_W{1'b0}};
      r_offset     <= OFFSET_ZERO;
      r_cnt        <= OFFSET_ZERO;
      r_kill       <= 1'b0;
      r_flush_pend <= 1'b0;
      r_ack        <= 1'b0;
      r_rdata      <= {XLEN{1'b0}};
      r_resp_word  <= {XLEN{1'b0}};
      r_mem_req    <= 1'b0;
      r_mem_addr   <= {XLEN{1'b0}};
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_kill       <= 1'b0;
          r_flush_pend <= 1'b0;
          if (w_lookup) begin
            if (w_hit) begin
              r_ack   <= 1'b1;
              r_rdata <= w_rd_data;
            end else begin
              r_tag      <= w_req.tag;
              r_index    <= w_req.index;
              r_offset   <= w_req.offset;
              r_cnt      <= OFFSET_ZERO;
              r_mem_req  <= 1'b1;
              r_mem_addr <= line_word_addr(w_req.tag, w_req.index, OFFSET_ZERO);
              r_state    <= REFILL;
            end
          end
        end
        REFILL: begin
          // A kill or flush never abandons the line; it only changes what happens at the end.
          if (bus.kill_i) begin
            r_kill <= 1'b1;
          end
          if (bus.flush_i) begin
            r_flush_pend <= 1'b1;
          end
          if (bus.mem_ack_i) begin
            if (r_cnt == r_offset) begin
              r_resp_word <= bus.mem_rdata_i;
            end
            if (w_last) begin
              r_mem_req <= 1'b0;
              r_state   <= RESP;
            end else begin
              r_cnt      <= r_cnt + OFFSET_ONE;
              r_mem_addr <= line_word_addr(r_tag, r_index, r_cnt + OFFSET_ONE);
            end
          end
        end
        RESP: begin
          if (!(r_kill || bus.kill_i)) begin
            r_ack   <= 1'b1;
            r_rdata <= r_resp_word;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_o      = r_ack;
  assign bus.r_data_o   = r_rdata;
  assign bus.mem_req_o  = r_mem_req;
  assign bus.mem_addr_o = r_mem_addr;

endmodule

// File: tb/tb_icache_lite.sv
// Self-checking bench for icache_lite: directed scenarios followed by a
// randomized phase, checked against a line-level reference model of a
// 16-set, 4-word direct-mapped cache over memory where word A holds A+0x100.
module tb_icache_lite;

  logic clk;
  logic rst;

  icache_lite_if bus_if();

  icache_lite dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Memory responder state.
  logic        resp_ack   = 1'b0;
  logic [31:0] resp_rdata = 32'h0;
  logic        stray_ack  = 1'b0;
  int          mem_lat_max = 0;
  int          wait_c      = 0;
  logic [31:0] mem_log [$];

  assign bus_if.mem_ack_i   = resp_ack | stray_ack;
  assign bus_if.mem_rdata_i = resp_rdata;

  // Reference model: per set, whether a line is resident and which line.
  bit          mv    [16];
  logic [27:0] mline [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = int'((a >> 4) % 16);
    return mv[s] && (mline[s] == a[31:4]);
  endfunction

  function automatic void model_install(input logic [31:0] a);
    int s;
    s = int'((a >> 4) % 16);
    mv[s]    = 1'b1;
    mline[s] = a[31:4];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory side: acks a pending word after a random wait, data = address + 0x100.
  initial begin
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (bus_if.mem_req_o) begin
        if (wait_c == 0) begin
          resp_ack   = 1'b1;
          resp_rdata = bus_if.mem_addr_o + 32'h100;
          mem_log.push_back(bus_if.mem_addr_o);
          wait_c = $urandom_range(0, mem_lat_max);
        end else begin
          wait_c--;
        end
      end
    end
  end

  // One fetch. inj: 0 none, 1 kill (requester drops req), 2 flush, 3 reset,
  // applied while the refill is on line word inj_word. Called at a negedge.
  task automatic fetch(input logic [31:0] a, input int inj, input int inj_word,
                       input bit exact_lat);
    logic [31:0] base;
    logic [31:0] got_data;
    bit exp_hit, got, done, injected, saw_mreq, rst_checked;
    int cyc, tail;
    exp_hit  = model_hit(a);
    base     = a & 32'hFFFF_FFF0;
    got_data = 32'h0;
    got = 0; done = 0; injected = 0; saw_mreq = 0; rst_checked = 0;
    cyc = 0; tail = 0;
    mem_log.delete();
    bus_if.req_i  = 1'b1;
    bus_if.addr_i = a;
    while (!done) begin
      @(negedge clk);
      cyc++;
      bus_if.kill_i  = 1'b0;
      bus_if.flush_i = 1'b0;
      rst            = 1'b0;
      if (bus_if.mem_req_o) saw_mreq = 1;
      if (injected && inj == 3 && !rst_checked) begin
        rst_checked = 1;
        check("rst_mid_ack", {31'h0, bus_if.ack_o}, 32'h0);
        check("rst_mid_mreq", {31'h0, bus_if.mem_req_o}, 32'h0);
      end
      if (bus_if.ack_o) begin
        got      = 1;
        got_data = bus_if.r_data_o;
        bus_if.req_i = 1'b0;
        done = 1;
      end else if (inj != 0 && !injected && bus_if.mem_req_o &&
                   bus_if.mem_addr_o == base + 32'(inj_word * 4)) begin
        injected = 1;
        case (inj)
          1: begin bus_if.kill_i = 1'b1; bus_if.req_i = 1'b0; end
          2: bus_if.flush_i = 1'b1;
          default: begin rst = 1'b1; bus_if.req_i = 1'b0; end
        endcase
      end else if (injected && (inj == 1 || inj == 3) && !bus_if.mem_req_o) begin
        tail++;
        if (tail >= 3) done = 1;
      end
      if (cyc >= 300) done = 1;
    end

    if (inj == 1 || inj == 3) begin
      check("no_ack_after_kill_or_rst", {31'h0, got}, 32'h0);
    end else begin
      check("ack_seen", {31'h0, got}, 32'h1);
      if (got) check("rdata", got_data, (a & 32'hFFFF_FFFC) + 32'h100);
    end

    if (exp_hit) begin
      check("hit_latency", cyc, 32'd1);
      check("hit_no_mreq", {31'h0, saw_mreq}, 32'h0);
    end else if (inj != 3) begin
      check("refill_words", mem_log.size(), 32'd4);
      for (int i = 0; i < 4 && i < mem_log.size(); i++)
        check("refill_addr", mem_log[i], base + 32'(i * 4));
      if (exact_lat && inj != 1) check("miss_latency", cyc, 32'd6);
    end

    case (inj)
      0, 1:    if (!exp_hit) model_install(a);
      default: model_clear();
    endcase
  endtask

  initial begin
    logic [31:0] a;
    int r;
    rst = 1'b1;
    bus_if.req_i   = 1'b0;
    bus_if.addr_i  = 32'h0;
    bus_if.kill_i  = 1'b0;
    bus_if.flush_i = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_ack", {31'h0, bus_if.ack_o}, 32'h0);
    check("reset_rdata", bus_if.r_data_o, 32'h0);
    check("reset_mreq", {31'h0, bus_if.mem_req_o}, 32'h0);
    check("reset_maddr", bus_if.mem_addr_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, exact latency with a single-cycle memory.
    mem_lat_max = 0;
    fetch(32'h0000_1004, 0, 0, 1'b1);

    // Hit streaming: four back-to-back requests, four consecutive acks.
    bus_if.req_i  = 1'b1;
    bus_if.addr_i = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_ack", {31'h0, bus_if.ack_o}, 32'h1);
      check("stream_data", bus_if.r_data_o, 32'h0000_1100 + 32'(i * 4));
      check("stream_mreq", {31'h0, bus_if.mem_req_o}, 32'h0);
      if (i < 3) bus_if.addr_i = 32'h0000_1000 + 32'((i + 1) * 4);
      else bus_if.req_i = 1'b0;
    end

    // Conflict in set 0.
    fetch(32'h0000_2000, 0, 0, 1'b1);
    fetch(32'h0000_1000, 0, 0, 1'b1);

    // Kill during word 2; line still installed, so 0x3004 hits.
    fetch(32'h0000_3000, 1, 2, 1'b1);
    fetch(32'h0000_3004, 0, 0, 1'b1);

    // Flush during word 1 of 0x4000; a line in set 1 must be lost too.
    fetch(32'h0000_1010, 0, 0, 1'b1);
    fetch(32'h0000_4000, 2, 1, 1'b1);
    fetch(32'h0000_4000, 0, 0, 1'b1);
    fetch(32'h0000_1010, 0, 0, 1'b1);

    // Reset during word 1, then a stray memory ack in IDLE.
    fetch(32'h0000_5000, 3, 1, 1'b1);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("stray_ack_mreq", {31'h0, bus_if.mem_req_o}, 32'h0);
    check("stray_ack_ack", {31'h0, bus_if.ack_o}, 32'h0);
    fetch(32'h0000_4000, 0, 0, 1'b1);
    fetch(32'h0000_3004, 0, 0, 1'b1);

    // Randomized phase: variable memory latency, mixed kills and flushes.
    mem_lat_max = 2;
    for (int n = 0; n < 150; n++) begin
      a = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 8) |
          (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2) |
          32'($urandom_range(0, 3));
      r = $urandom_range(0, 15);
      if (r == 0) begin
        bus_if.req_i   = 1'b0;
        bus_if.flush_i = 1'b1;
        @(negedge clk);
        bus_if.flush_i = 1'b0;
        check("idle_flush_ack", {31'h0, bus_if.ack_o}, 32'h0);
        model_clear();
      end
      if (!model_hit(a) && r == 1)
        fetch(a, 1, $urandom_range(0, 3), 1'b0);
      else if (!model_hit(a) && r == 2)
        fetch(a, 2, $urandom_range(0, 3), 1'b0);
      else
        fetch(a, 0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_lite.md
Name: icache_lite

Overview:
- Direct-mapped, read-only instruction cache. It is the responder on the prefetch→icache request/ack interface (addr/req in, r_data/ack out).
- Hits are served with one-cycle registered latency.
- Misses refill a full line from instruction memory, one word at a time, over a simple req/ack bus.
- Sits between the prefetch stage and the memory/bus side of the core.

Parameters:
- XLEN, 32, data/address width.
- SETS, 16, number of lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  fetch request (maps to type_if2icache_s.req).
- addr_i  in  XLEN  fetch address (type_if2icache_s.addr); bits [1:0] ignored.
- kill_i  in  1  requester clear/redirect; drop any pending response.
- flush_i  in  1  invalidate all lines (fence.i).
- r_data_o  out  XLEN  returned instruction word (type_icache2if_s.r_data).
- ack_o  out  1  one-cycle response strobe (type_icache2if_s.ack).
- mem_req_o  out  1  refill word request.
- mem_addr_o  out  XLEN  word-aligned refill address.
- mem_rdata_i  in  XLEN  refill data.
- mem_ack_i  in  1  refill word accepted; data valid this cycle.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, all valid bits 0, ack_o 0, r_data_o 0, mem_req_o 0, mem_addr_o 0, word counter 0.
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- FSM states: IDLE, REFILL, RESP.
- IDLE:
  - Lookup every cycle with req_i=1, kill_i=0, flush_i=0.
  - Hit: r_data_o ← word and ack_o=1 on the next cycle; stay in IDLE. Back-to-back hits give one ack per cycle.
  - Miss: latch addr; clear counter; → REFILL.
  - req_i=0, kill_i=1 or flush_i=1: no lookup, ack_o=0 next cycle.
- Handshake: requester holds req_i/addr_i stable until ack_o. A request present in the ack cycle is a new request.
- REFILL:
  - mem_req_o=1; mem_addr_o = {line base, counter, 2'b00}.
  - Request held until mem_ack_i. On mem_ack_i, write mem_rdata_i into data[index][counter] and increment the counter.
  - Words are fetched in order 0..LINE_WORDS-1; no critical-word-first.
  - On the ack of the last word: set tag[index]; set valid[index] unless flush is pending; → RESP.
  - mem_req_o deasserts the cycle after the final mem_ack_i.
- RESP:
  - If no kill arrived since the miss, ack_o=1 and r_data_o = latched word, for one cycle.
  - Always → IDLE next cycle.
  - Miss-to-ack latency = LINE_WORDS × (memory latency) + 2 cycles.
- kill_i during REFILL: the refill completes (bus transaction is never abandored mid-line) and the line is still installed. A sticky kill flag suppresses the RESP ack. The flag clears on return to IDLE.
- flush_i:
  - Clears all valid bits at the next edge, in any state.
  - During REFILL, it sets a pending-flush flag so the line being filled is not validated. The response is still returned unless kill is also set.
  - flush_i and a hit in the same cycle: flush wins, no ack, and the request is re-looked-up later as a miss.
- Refill overwrites the victim line regardless of its valid state. There is no dirty state.
- rst mid-REFILL: immediate return to reset values. mem_req_o drops next cycle; any late mem_ack_i in IDLE is ignored.
- Counter wrap: a log2(LINE_WORDS)-bit counter, terminal at LINE_WORDS-1. The RESP decision uses the terminal flag, not the wrapped value.

Decomposition:
- cache_defs.svh holds:
  - ICACHE_LITE_SETS and ICACHE_LITE_LINE_WORDS defaults
  - derived OFFSET_W/INDEX_W/TAG_W macros
  - typedef enum type_icache_lite_state_e {IDLE, REFILL, RESP}
- Sub-module icache_lite_array: tag/valid/data storage with:
  - one read port (index, offset)
  - one word-write port
  - tag+valid set
  - global valid clear
- The FSM, flags and bus interface stay in icache_lite.

Test Plan:
- Cold miss: SETS=16, LINE_WORDS=4, req at 0x0000_1004, memory 1-cycle ack, mem word at address A = A+0x100 → mem_addr 0x1000,0x1004,0x1008,0x100C; ack_o with r_data 0x0000_1104 at miss+6 cycles.
- Hit streaming: after the fill, req 0x1000,0x1004,0x1008,0x100C on consecutive cycles → four consecutive acks with data 0x1100..0x110C; mem_req_o stays 0.
- Conflict: fill 0x1000, then req 0x2000 (same index) → refill; a later req 0x1000 misses again.
- Kill mid-refill: kill_i pulse during word 2 of the 0x3000 fill → all 4 words fetched, no ack_o; a following req 0x3004 hits with ack next cycle.
- Flush mid-refill: flush_i during the 0x4000 fill → ack returned for 0x4000; the following req 0x4000 misses; previously valid 0x1000 also misses.
- Reset mid-refill: rst during word 1 → ack_o 0, mem_req_o 0 next cycle, all lines miss afterwards.
